// File: rtl/idli_pkg.sv
// Shared constants and types for the idli nibble-serial datapath.
package idli_pkg;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 16;
    localparam int NIBBLES  = 4;
    localparam int RF_NREGS = 8;
    localparam int RF_AW    = $clog2(RF_NREGS);

    typedef logic [RF_AW-1:0]    idli_pkg_rf_addr_t;
    typedef logic [NIBBLE_W-1:0] idli_pkg_nibble_t;

endpackage

// File: rtl/idli_ctr_m.sv
// Nibble sequencer for serial stages: busy flag, 2-bit nibble counter and the
// last-cycle strobe. A start is accepted when idle or on the last nibble, so
// operations can run back to back with no bubble.
module idli_ctr_m
    import idli_pkg::*;
(
    input  logic       i_gck,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_busy,
    output logic [1:0] o_ctr,
    output logic       o_last_cycle,
    output logic       o_accept
);

    logic       r_busy;
    logic [1:0] r_ctr;

    assign o_busy       = r_busy;
    assign o_ctr        = r_ctr;
    assign o_last_cycle = r_busy && (r_ctr == 2'(NIBBLES - 1));
    assign o_accept     = i_start && (!r_busy || o_last_cycle);

    // Advance the nibble counter; a start on the last nibble restarts at 0.
    always_ff @(posedge i_gck or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_ctr  <= 2'd0;
        end else if (o_accept) begin
            r_busy <= 1'b1;
            r_ctr  <= 2'd0;
        end else if (r_busy) begin
            if (o_last_cycle) begin
                r_busy <= 1'b0;
                r_ctr  <= 2'd0;
            end else begin
                r_ctr <= r_ctr + 2'd1;
            end
        end
    end

endmodule

// File: rtl/idli_rf_m.sv
// Nibble-serial register file. Presents one nibble of each read operand per
// busy cycle (LSB nibble first), collects result nibbles in a shadow and
// commits the whole word on the last cycle, so an op reading its own write
// target sees the old value throughout.
// Build option: IDLI_RF_ZERO_REG_EN makes register 0 a hardwired zero.
module idli_rf_m
    import idli_pkg::*;
#(
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  i_rf_gck,
    input  logic                  i_rf_rst,
    input  logic                  i_rf_start,
    input  logic [AW-1:0]         i_rf_ra,
    input  logic [AW-1:0]         i_rf_rb,
    input  logic [AW-1:0]         i_rf_wa,
    input  logic                  i_rf_wr_en,
    input  logic [NIBBLE_W-1:0]   i_rf_wr_data,
    output logic [NIBBLE_W-1:0]   o_rf_lhs,
    output logic [NIBBLE_W-1:0]   o_rf_rhs,
    output logic                  o_rf_busy,
    output logic                  o_rf_last_cycle
);

`ifdef IDLI_RF_ZERO_REG_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    logic [WORD_W-1:0]              r_mem [FIRST:NREGS-1];
    logic [AW-1:0]                  r_ra;
    logic [AW-1:0]                  r_rb;
    logic [AW-1:0]                  r_wa;
    logic                           r_wr_en;
    logic [WORD_W-NIBBLE_W-1:0]     r_shadow;

    logic                           w_busy;
    logic [1:0]                     w_ctr;
    logic                           w_last;
    logic                           w_accept;
    logic [WORD_W-1:0]              w_word_a;
    logic [WORD_W-1:0]              w_word_b;
    idli_pkg_nibble_t               w_nib_a;
    idli_pkg_nibble_t               w_nib_b;

    idli_ctr_m u_ctr (
        .i_gck        (i_rf_gck),
        .i_rst        (i_rf_rst),
        .i_start      (i_rf_start),
        .o_busy       (w_busy),
        .o_ctr        (w_ctr),
        .o_last_cycle (w_last),
        .o_accept     (w_accept)
    );

    // Word read mux; an address without storage (hardwired r0) reads zero.
    always_comb begin
        w_word_a = '0;
        w_word_b = '0;
        for (int i = FIRST; i < NREGS; i++) begin
            if (r_ra == AW'(i)) w_word_a = r_mem[i];
            if (r_rb == AW'(i)) w_word_b = r_mem[i];
        end
    end

    assign w_nib_a         = w_word_a[{w_ctr, 2'b00} +: NIBBLE_W];
    assign w_nib_b         = w_word_b[{w_ctr, 2'b00} +: NIBBLE_W];
    assign o_rf_lhs        = w_busy ? w_nib_a : '0;
    assign o_rf_rhs        = w_busy ? w_nib_b : '0;
    assign o_rf_busy       = w_busy;
    assign o_rf_last_cycle = w_last;

    // Shadow capture, end-of-op commit and operand latching on accept.
    always_ff @(posedge i_rf_gck or posedge i_rf_rst) begin
        if (i_rf_rst) begin
            for (int i = FIRST; i < NREGS; i++) r_mem[i] <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_wa     <= '0;
            r_wr_en  <= 1'b0;
            r_shadow <= '0;
        end else begin
            if (w_busy && !w_last) begin
                case (w_ctr)
                    2'd0:    r_shadow[3:0]  <= i_rf_wr_data;
                    2'd1:    r_shadow[7:4]  <= i_rf_wr_data;
                    default: r_shadow[11:8] <= i_rf_wr_data;
                endcase
            end
            if (w_last && r_wr_en) begin
                for (int i = FIRST; i < NREGS; i++) begin
                    if (r_wa == AW'(i)) r_mem[i] <= {i_rf_wr_data, r_shadow};
                end
            end
            if (w_accept) begin
                r_ra    <= i_rf_ra;
                r_rb    <= i_rf_rb;
                r_wa    <= i_rf_wa;
                r_wr_en <= i_rf_wr_en;
            end
        end
    end

endmodule

// File: tb/tb_idli_rf_m.sv
// Scoreboard bench for idli_rf_m: each issued op pushes its four expected
// (lhs, rhs, last) beats from a reference memory; the negedge monitor pops
// and compares them while the DUT is busy.
module tb_idli_rf_m;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_rf_start = 1'b0;
    logic [2:0] i_rf_ra = '0;
    logic [2:0] i_rf_rb = '0;
    logic [2:0] i_rf_wa = '0;
    logic       i_rf_wr_en = 1'b0;
    logic [3:0] i_rf_wr_data = '0;
    logic [3:0] o_rf_lhs;
    logic [3:0] o_rf_rhs;
    logic       o_rf_busy;
    logic       o_rf_last_cycle;

    idli_rf_m #(.NREGS(8)) dut (
        .i_rf_gck        (clk),
        .i_rf_rst        (rst),
        .i_rf_start      (i_rf_start),
        .i_rf_ra         (i_rf_ra),
        .i_rf_rb         (i_rf_rb),
        .i_rf_wa         (i_rf_wa),
        .i_rf_wr_en      (i_rf_wr_en),
        .i_rf_wr_data    (i_rf_wr_data),
        .o_rf_lhs        (o_rf_lhs),
        .o_rf_rhs        (o_rf_rhs),
        .o_rf_busy       (o_rf_busy),
        .o_rf_last_cycle (o_rf_last_cycle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  wa;
        logic        we;
        logic [15:0] data;
        logic        glitch;
    } op_t;

    typedef struct {
        logic [3:0] lhs;
        logic [3:0] rhs;
        logic       last;
    } beat_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] model [8];
    beat_t       sb [$];
    bit          mon_en = 1'b0;
    int          busy_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Drive start for one op and queue its expected beats, then update the model.
    task automatic start_op(input op_t op);
        beat_t b;
        i_rf_start = 1'b1;
        i_rf_ra    = op.ra;
        i_rf_rb    = op.rb;
        i_rf_wa    = op.wa;
        i_rf_wr_en = op.we;
        for (int n = 0; n < 4; n++) begin
            b.lhs  = model[op.ra][4*n +: 4];
            b.rhs  = model[op.rb][4*n +: 4];
            b.last = (n == 3);
            sb.push_back(b);
        end
        if (op.we) begin
`ifdef IDLI_RF_ZERO_REG_EN
            if (op.wa != 3'd0) model[op.wa] = op.data;
`else
            model[op.wa] = op.data;
`endif
        end
    endtask

    // Run a chain of ops back to back (start held across the last cycle).
    task automatic run_seq(input op_t ops[$]);
        int base = busy_cyc;
        start_op(ops[0]);
        @(posedge clk); #1;
        for (int k = 0; k < ops.size(); k++) begin
            i_rf_start = 1'b0;
            for (int n = 0; n < 4; n++) begin
                i_rf_wr_data = ops[k].data[4*n +: 4];
                if (ops[k].glitch && n == 1) begin
                    i_rf_start = 1'b1;
                    i_rf_ra    = ~ops[k].ra;
                    i_rf_rb    = ~ops[k].rb;
                    i_rf_wa    = ~ops[k].wa;
                    i_rf_wr_en = ~ops[k].we;
                end else if (n == 2) begin
                    i_rf_start = 1'b0;
                end
                if (n == 3 && k + 1 < ops.size()) start_op(ops[k+1]);
                @(posedge clk); #1;
            end
        end
        i_rf_wr_data = 4'hD;
        @(posedge clk); #1;
        chk("busy_cycles", busy_cyc - base, 4 * ops.size());
        chk("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    function automatic op_t mk(input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] wa,
                               input logic we, input logic [15:0] data);
        op_t o;
        o.ra = ra; o.rb = rb; o.wa = wa; o.we = we; o.data = data; o.glitch = 1'b0;
        return o;
    endfunction

    // Compare every busy beat against the scoreboard; idle outputs must be zero.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (o_rf_busy) begin
                busy_cyc++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    beat_t b;
                    b = sb.pop_front();
                    chk("lhs", o_rf_lhs, b.lhs);
                    chk("rhs", o_rf_rhs, b.rhs);
                    chk("last", o_rf_last_cycle, b.last);
                end
            end else begin
                chk("idle_lhs", o_rf_lhs, 0);
                chk("idle_rhs", o_rf_rhs, 0);
                chk("idle_last", o_rf_last_cycle, 0);
            end
        end
    end

    initial begin
        op_t q [$];
        op_t g;
        for (int i = 0; i < 8; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", o_rf_busy, 0);
        chk("rst_last", o_rf_last_cycle, 0);
        chk("rst_lhs", o_rf_lhs, 0);
        rst = 1'b0;
        i_rf_wr_data = 4'h9;
        @(posedge clk); #1;
        chk("idle_busy", o_rf_busy, 0);
        mon_en = 1'b1;

        // every register reads zero after reset
        for (int i = 0; i < 8; i += 2) begin
            q = {mk(3'(i), 3'(i + 1), 3'd0, 1'b0, 16'h0)};
            run_seq(q);
        end

        // preload r1 and read it back on both ports
        q = {mk(3'd0, 3'd0, 3'd1, 1'b1, 16'hA5C3)};
        run_seq(q);
        q = {mk(3'd1, 3'd1, 3'd0, 1'b0, 16'h0)};
        run_seq(q);

        // read-during-write sees old value, next op sees new value
        q = {mk(3'd0, 3'd0, 3'd2, 1'b1, 16'h1234)};
        run_seq(q);
        q = {mk(3'd2, 3'd1, 3'd2, 1'b1, 16'hFFFF)};
        run_seq(q);
        q = {mk(3'd2, 3'd2, 3'd0, 1'b0, 16'h0)};
        run_seq(q);

        // back-to-back: second op reads first op's commit
        q = {mk(3'd1, 3'd2, 3'd5, 1'b1, 16'h5A69), mk(3'd5, 3'd1, 3'd6, 1'b1, 16'h0F1E),
             mk(3'd6, 3'd5, 3'd7, 1'b0, 16'hCAFE)};
        run_seq(q);

        // start mid-op is ignored (addresses and wr_en not re-latched)
        g = mk(3'd1, 3'd6, 3'd4, 1'b1, 16'h9999);
        g.glitch = 1'b1;
        q = {g};
        run_seq(q);
        q = {mk(3'd4, 3'd3, 3'd0, 1'b0, 16'h0)};
        run_seq(q);

        // reset during a write at ctr=2 aborts immediately, no commit
        mon_en = 1'b0;
        i_rf_start = 1'b1; i_rf_ra = 3'd4; i_rf_rb = 3'd4; i_rf_wa = 3'd3; i_rf_wr_en = 1'b1;
        @(posedge clk); #1;
        i_rf_start = 1'b0; i_rf_wr_data = 4'h7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", o_rf_busy, 1);
        chk("pre_rst_lhs", o_rf_lhs, 4'h9);
        rst = 1'b1;
        #1;
        chk("abort_busy", o_rf_busy, 0);
        chk("abort_last", o_rf_last_cycle, 0);
        chk("abort_lhs", o_rf_lhs, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        q = {mk(3'd3, 3'd4, 3'd0, 1'b0, 16'h0)};
        run_seq(q);

        // register 0 behaviour
        q = {mk(3'd0, 3'd0, 3'd0, 1'b1, 16'hBEEF)};
        run_seq(q);
        q = {mk(3'd0, 3'd0, 3'd0, 1'b0, 16'h0)};
        run_seq(q);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
